// File: rtl/fu_mul_lat3_32b.sv
// Three-stage pipelined 32-bit multiplier function unit with a trigger port,
// an operand port and a global lock that freezes every register.
module fu_mul_lat3_32b (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_glock,
  input  logic [31:0] io_o1data,
  input  logic        io_o1load,
  input  logic [31:0] io_t1data,
  input  logic        io_t1load,
  input  logic [1:0]  io_t1opcode,
  output logic [31:0] io_r1data,
  output logic        io_r1valid
);

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULHU  = 2'd1,
    OP_MULHS  = 2'd2,
    OP_MULHSU = 2'd3
  } opcode_e;

  logic [31:0] o1_q;
  logic [31:0] s1A_q, s1B_q;
  opcode_e     s1Op_q;
  logic        s1Valid_q;
  logic [63:0] s2Prod_q;
  opcode_e     s2Op_q;
  logic        s2Valid_q;
  logic [31:0] r1Data_q;
  logic        r1Valid_q;

  logic               trigger;
  logic [31:0]        s1B_d;
  logic signed [32:0] aExt, bExt;
  logic signed [65:0] prodFull;
  logic [63:0]        s2Prod_d;
  logic [31:0]        r1Data_d;

  assign trigger = io_t1load & ~io_glock;
  assign s1B_d   = io_o1load ? io_o1data : o1_q;

  // A 33-bit signed multiply covers all four signedness combinations.
  always_comb begin
    aExt     = $signed({(s1Op_q == OP_MULHS || s1Op_q == OP_MULHSU) & s1A_q[31], s1A_q});
    bExt     = $signed({(s1Op_q == OP_MULHS) & s1B_q[31], s1B_q});
    prodFull = aExt * bExt;
    s2Prod_d = prodFull[63:0];
  end

  always_comb begin
    r1Data_d = (s2Op_q == OP_MUL) ? s2Prod_q[31:0] : s2Prod_q[63:32];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o1_q      <= '0;
      s1A_q     <= '0;
      s1B_q     <= '0;
      s1Op_q    <= OP_MUL;
      s1Valid_q <= 1'b0;
      s2Prod_q  <= '0;
      s2Op_q    <= OP_MUL;
      s2Valid_q <= 1'b0;
      r1Data_q  <= '0;
      r1Valid_q <= 1'b0;
    end else if (!io_glock) begin
      if (io_o1load) begin
        o1_q <= io_o1data;
      end
      s1Valid_q <= trigger;
      if (trigger) begin
        s1A_q  <= io_t1data;
        s1B_q  <= s1B_d;
        s1Op_q <= opcode_e'(io_t1opcode);
      end
      s2Prod_q  <= s2Prod_d;
      s2Op_q    <= s1Op_q;
      s2Valid_q <= s1Valid_q;
      r1Valid_q <= s2Valid_q;
      if (s2Valid_q) begin
        r1Data_q <= r1Data_d;
      end
    end
  end

  assign io_r1data  = r1Data_q;
  assign io_r1valid = r1Valid_q;

endmodule

// File: tb/tb_fu_mul_lat3_32b.sv
// Directed self-checking bench for fu_mul_lat3_32b: an opcode vector table
// plus hand sequences for latency, bypass, back-to-back, lock and reset.
module tb_fu_mul_lat3_32b;

  logic        clk;
  logic        reset;
  logic        io_glock;
  logic [31:0] io_o1data;
  logic        io_o1load;
  logic [31:0] io_t1data;
  logic        io_t1load;
  logic [1:0]  io_t1opcode;
  logic [31:0] io_r1data;
  logic        io_r1valid;

  int nApplied;
  int nMiscompares;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs[13];

  fu_mul_lat3_32b dut (
    .clk        (clk),
    .reset      (reset),
    .io_glock   (io_glock),
    .io_o1data  (io_o1data),
    .io_o1load  (io_o1load),
    .io_t1data  (io_t1data),
    .io_t1load  (io_t1load),
    .io_t1opcode(io_t1opcode),
    .io_r1data  (io_r1data),
    .io_r1valid (io_r1valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, take one rising edge, then settle past it.
  task automatic applyStimulus(input logic trig, input logic [31:0] a, input logic [1:0] op,
                               input logic ld, input logic [31:0] b, input logic lock);
    io_t1load   = trig;
    io_t1data   = a;
    io_t1opcode = op;
    io_o1load   = ld;
    io_o1data   = b;
    io_glock    = lock;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nApplied     = 0;
    nMiscompares = 0;
    vecs[0]  = '{32'h00000006, 32'h00000007, 2'd0, 32'h0000002A};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 32'h00000001};
    vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'd1, 32'hFFFFFFFE};
    vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'd2, 32'h00000000};
    vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'd3, 32'hFFFFFFFF};
    vecs[5]  = '{32'h80000000, 32'h00000002, 2'd2, 32'hFFFFFFFF};
    vecs[6]  = '{32'h0000FFFF, 32'h0000FFFF, 2'd0, 32'hFFFE0001};
    vecs[7]  = '{32'h00010000, 32'h00010000, 2'd1, 32'h00000001};
    vecs[8]  = '{32'h80000000, 32'h80000000, 2'd2, 32'h40000000};
    vecs[9]  = '{32'h80000000, 32'h80000000, 2'd1, 32'h40000000};
    vecs[10] = '{32'h80000000, 32'h80000000, 2'd3, 32'hC0000000};
    vecs[11] = '{32'h00000002, 32'hFFFFFFFF, 2'd3, 32'h00000001};
    vecs[12] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 2'd2, 32'h3FFFFFFF};

    reset = 1'b0;
    io_glock = 1'b0; io_o1load = 1'b0; io_o1data = '0;
    io_t1load = 1'b0; io_t1data = '0; io_t1opcode = '0;
    #2;
    checkOutput("reset_data", io_r1data, 32'h0);
    checkOutput("reset_valid", {31'b0, io_r1valid}, 32'h0);
    idle(2);
    reset = 1'b1;

    // Operand load, then trigger next cycle; first trigger after reset.
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 32'd3, 1'b0);
    applyStimulus(1'b1, 32'd5, 2'd0, 1'b0, 32'h0, 1'b0);
    idle(1);
    checkOutput("basic_early_valid", {31'b0, io_r1valid}, 32'h0);
    idle(1);
    checkOutput("basic_data", io_r1data, 32'h0000000F);
    checkOutput("basic_valid", {31'b0, io_r1valid}, 32'h1);
    idle(1);
    checkOutput("basic_valid_drop", {31'b0, io_r1valid}, 32'h0);
    checkOutput("basic_data_hold", io_r1data, 32'h0000000F);

    // In-flight operand must not see a later o1 write.
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 32'd10, 1'b0);
    applyStimulus(1'b1, 32'd2, 2'd0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 32'd100, 1'b0);
    idle(1);
    checkOutput("capture_data", io_r1data, 32'd20);

    // Back-to-back triggers.
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, i, 2'd0, 1'b1, i, 1'b0);
    checkOutput("b2b_r1", io_r1data, 32'd1);
    checkOutput("b2b_v1", {31'b0, io_r1valid}, 32'h1);
    idle(1);
    checkOutput("b2b_r2", io_r1data, 32'd4);
    checkOutput("b2b_v2", {31'b0, io_r1valid}, 32'h1);
    idle(1);
    checkOutput("b2b_r3", io_r1data, 32'd9);
    checkOutput("b2b_v3", {31'b0, io_r1valid}, 32'h1);
    idle(1);
    checkOutput("b2b_v_end", {31'b0, io_r1valid}, 32'h0);

    // Lock for two edges after the trigger edge; writes during lock are ignored.
    applyStimulus(1'b1, 32'd4, 2'd0, 1'b1, 32'd4, 1'b0);
    applyStimulus(1'b1, 32'd99, 2'd0, 1'b1, 32'd55, 1'b1);
    checkOutput("lock_hold1", io_r1data, 32'd9);
    applyStimulus(1'b1, 32'd99, 2'd0, 1'b1, 32'd55, 1'b1);
    checkOutput("lock_hold2", io_r1data, 32'd9);
    checkOutput("lock_valid", {31'b0, io_r1valid}, 32'h0);
    idle(1);
    checkOutput("lock_early", {31'b0, io_r1valid}, 32'h0);
    idle(1);
    checkOutput("lock_result", io_r1data, 32'd16);
    checkOutput("lock_result_v", {31'b0, io_r1valid}, 32'h1);
    idle(1);
    checkOutput("lock_no_extra", {31'b0, io_r1valid}, 32'h0);
    checkOutput("lock_no_extra_d", io_r1data, 32'd16);

    // o1 still holds 4; a held valid must survive a lock.
    applyStimulus(1'b1, 32'd1, 2'd0, 1'b0, 32'h0, 1'b0);
    idle(2);
    checkOutput("lock_o1_kept", io_r1data, 32'd4);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b1);
    checkOutput("lock_valid_held", {31'b0, io_r1valid}, 32'h1);
    idle(1);
    checkOutput("lock_valid_rel", {31'b0, io_r1valid}, 32'h0);

    // Reset one edge after a trigger discards it.
    applyStimulus(1'b1, 32'd9, 2'd0, 1'b1, 32'd9, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_data", io_r1data, 32'h0);
    checkOutput("rst_mid_valid", {31'b0, io_r1valid}, 32'h0);
    idle(2);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checkOutput("rst_quiet_valid", {31'b0, io_r1valid}, 32'h0);
      checkOutput("rst_quiet_data", io_r1data, 32'h0);
    end
    applyStimulus(1'b1, 32'd5, 2'd0, 1'b0, 32'h0, 1'b0);
    idle(2);
    checkOutput("rst_o1_cleared", io_r1data, 32'h0);
    checkOutput("rst_o1_valid", {31'b0, io_r1valid}, 32'h1);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, vecs[i].a, vecs[i].op, 1'b1, vecs[i].b, 1'b0);
      idle(2);
      checkOutput($sformatf("vec%0d_data", i), io_r1data, vecs[i].expected);
      checkOutput($sformatf("vec%0d_valid", i), {31'b0, io_r1valid}, 32'h1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
    $finish;
  end

endmodule

// File: doc/fu_mul_lat3_32b.md
FU_MUL_LAT3_32B -- requirements
Module: fu_mul_lat3_32b

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-003 SHALL have ports: io_glock  in  1  global lock; 1 freezes all state.
REQ-004 SHALL have ports: io_o1data  in  32  operand port data.
REQ-005 SHALL have ports: io_o1load  in  1  operand port write strobe.
REQ-006 SHALL have ports: io_t1data  in  32  trigger port data.
REQ-007 SHALL have ports: io_t1load  in  1  trigger port write strobe; starts an operation.
REQ-008 SHALL have ports: io_t1opcode  in  2  operation select.
REQ-009 SHALL have ports: io_r1data  out  32  result register, fed to the register file write port (io_t1data of rf_1wr_1rd).
REQ-010 SHALL have ports: io_r1valid  out  1  1 in the cycle after a new result lands in io_r1data (debug/verification aid).

Function
REQ-011 Operand register o1 SHALL load io_o1data on an edge where io_o1load=1 and io_glock=0; otherwise it holds.
REQ-012 Trigger accepted SHALL mean io_t1load=1 and io_glock=0 at the edge.
REQ-013 On trigger, stage 1 SHALL capture A=io_t1data, B=(io_o1load ? io_o1data : o1), opcode, valid=1; same-cycle operand write SHALL bypass to B.
REQ-014 With no trigger and io_glock=0, stage-1 valid SHALL clear to 0.
REQ-015 Stage 2 SHALL register the full 64-bit product of stage-1 operands, sign-extended per opcode, plus opcode and valid.
REQ-016 Stage 3 SHALL select 32 bits per opcode into io_r1data only when stage-2 valid=1; otherwise io_r1data holds its last value.
REQ-017 Opcode 0 MUL: product[31:0], operands unsigned.
REQ-018 Opcode 1 MULHU: product[63:32], A and B unsigned.
REQ-019 Opcode 2 MULHS: product[63:32], A and B signed two's complement.
REQ-020 Opcode 3 MULHSU: product[63:32], A signed, B unsigned.
REQ-021 Latency SHALL be exactly 3 unlocked edges from trigger edge to io_r1data update.
REQ-022 Initiation interval SHALL be 1: a trigger every unlocked cycle yields one result per unlocked cycle, in order.
REQ-023 io_glock=1 SHALL freeze o1, all stage registers, valids, io_r1data and io_r1valid; no trigger or operand write is accepted; locked edges SHALL NOT count toward latency.
REQ-024 io_r1valid SHALL be 1 for exactly one unlocked edge period per result; under glock it holds its value.
REQ-025 Operations in flight SHALL be independent of subsequent o1 writes (operands captured at trigger).

Reset
REQ-026 reset=0 SHALL asynchronously clear o1, all stage data and valids, io_r1data=32'h0, io_r1valid=0.
REQ-027 reset asserted mid-operation SHALL discard all in-flight operations; no result appears after release.
REQ-028 After reset release the first trigger SHALL behave per REQ-021 with no extra delay.

Verification
REQ-029 Basic: o1load o1data=3; next cycle t1load t1data=5 op0 -> io_r1data=32'h0000000F after 3 edges, io_r1valid pulse 1 cycle.
REQ-030 Bypass: same cycle o1load o1data=7, t1load t1data=6 op0 -> io_r1data=32'h0000002A.
REQ-031 Opcodes with A=B=32'hFFFFFFFF: op0 -> 32'h00000001; op1 -> 32'hFFFFFFFE; op2 -> 32'h00000000; op3 -> 32'hFFFFFFFF; A=32'h80000000,B=2 op2 -> 32'hFFFFFFFF.
REQ-032 Back-to-back: triggers 1x1,2x2,3x3 op0 on consecutive cycles -> io_r1data 1,4,9 on consecutive cycles, io_r1valid high 3 cycles.
REQ-033 Lock: trigger 4x4 op0, io_glock=1 for 2 cycles after first edge -> result 16 appears after 5 edges; t1load during lock ignored; io_r1data unchanged during lock.
REQ-034 Reset: trigger 9x9, assert reset 1 edge later -> io_r1data=0, io_r1valid=0 immediately and remain 0 with no further triggers.
